// File: rtl/lcd_pkg.sv
// Shared FSM state type and protocol byte constants for the LCD line sequencer.
// The command byte helper folds in the optional VCOM bit (macro LCD_VCOM_EN).
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DUMMY,
    ST_TRAIL
  } state_t;

  localparam logic [7:0] CMD_WRITE  = 8'h80;
  localparam logic [7:0] VCOM_MASK  = 8'h40;
  localparam logic [7:0] DUMMY_BYTE = 8'h00;

  function automatic logic [7:0] cmd_byte(input logic vcom);
    return vcom ? (CMD_WRITE | VCOM_MASK) : CMD_WRITE;
  endfunction

endpackage

// File: rtl/lcd_line_sequencer.sv
// Frame sequencer for a memory-in-pixel LCD: command, then per line address/data/dummy, then trailer.
// Optional macro LCD_VCOM_EN alternates the VCOM bit of the command byte every frame.
module lcd_line_sequencer
  import lcd_pkg::*;
#(
  parameter int LINE_BYTES = 50,
  parameter int NUM_LINES  = 240
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rempty,
  input  logic [7:0] i_rdata,
  output logic       o_rinc,
  output logic [7:0] o_tdata,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_cs,
  output logic       o_busy,
  output logic       o_done
);

  localparam int LW = $clog2(NUM_LINES + 1);
  localparam int BW = $clog2(LINE_BYTES + 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(NUM_LINES);
  localparam logic [BW-1:0] LAST_BYTE = BW'(LINE_BYTES - 1);

  state_t        state_reg, state_next;
  logic [LW-1:0] line_reg, line_next;
  logic [BW-1:0] byte_reg, byte_next;
  logic          done_reg, done_next;
  logic          vcom;
  logic          tvalid_next;
  logic [7:0]    tdata_next;
  logic          rinc_next;

`ifdef LCD_VCOM_EN
  logic vcom_reg;

  // VCOM flips on the same edge that raises o_done, so the next frame sees the new polarity.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vcom_reg <= 1'b0;
    end else if (done_next) begin
      vcom_reg <= ~vcom_reg;
    end
  end

  assign vcom = vcom_reg;
`else
  assign vcom = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      line_reg  <= '0;
      byte_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      line_reg  <= line_next;
      byte_reg  <= byte_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    line_next   = line_reg;
    byte_next   = byte_reg;
    done_next   = 1'b0;
    tvalid_next = 1'b0;
    tdata_next  = 8'h00;
    rinc_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next = ST_CMD;
        end
      end

      ST_CMD: begin
        tvalid_next = 1'b1;
        tdata_next  = cmd_byte(vcom);
        if (i_tready) begin
          state_next = ST_ADDR;
          line_next  = LW'(1);
        end
      end

      ST_ADDR: begin
        tvalid_next = 1'b1;
        tdata_next  = 8'(line_reg);
        if (i_tready) begin
          state_next = ST_DATA;
          byte_next  = '0;
        end
      end

      // FIFO head passes straight through; an empty FIFO simply stalls the line.
      ST_DATA: begin
        tvalid_next = ~i_rempty;
        tdata_next  = i_rdata;
        rinc_next   = ~i_rempty & i_tready;
        if (~i_rempty && i_tready) begin
          byte_next = byte_reg + BW'(1);
          if (byte_reg == LAST_BYTE) begin
            state_next = ST_DUMMY;
          end
        end
      end

      ST_DUMMY: begin
        tvalid_next = 1'b1;
        tdata_next  = DUMMY_BYTE;
        if (i_tready) begin
          if (line_reg < LAST_LINE) begin
            line_next  = line_reg + LW'(1);
            state_next = ST_ADDR;
          end else begin
            state_next = ST_TRAIL;
          end
        end
      end

      ST_TRAIL: begin
        tvalid_next = 1'b1;
        tdata_next  = DUMMY_BYTE;
        if (i_tready) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Handshakes are masked during reset so neither the FIFO nor the serializer moves.
  assign o_tvalid = tvalid_next & ~i_rst;
  assign o_rinc   = rinc_next & ~i_rst;
  assign o_tdata  = tdata_next;
  assign o_cs     = (state_reg != ST_IDLE);
  assign o_busy   = (state_reg != ST_IDLE);
  assign o_done   = done_reg;

endmodule

// File: tb/tb_lcd_line_sequencer.sv
// Self-checking bench for lcd_line_sequencer: directed frames plus randomized ready/empty stalls,
// compared against a byte-stream model built from the FIFO contents. Honours LCD_VCOM_EN.
module tb_lcd_line_sequencer;

  localparam int LB = 2;
  localparam int NL = 2;
  localparam int FRAME_DATA = LB * NL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rempty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       tready = 1'b0;
  logic       rinc, tvalid, cs, busy, done;
  logic [7:0] tdata;

  always #5 clk = ~clk;

  lcd_line_sequencer #(.LINE_BYTES(LB), .NUM_LINES(NL)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rempty(rempty), .i_rdata(rdata),
    .o_rinc(rinc), .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(tready),
    .o_cs(cs), .o_busy(busy), .o_done(done)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] fifo[$];
  logic [7:0] obs[$];
  bit         vcom_model = 1'b0;
  int         pops = 0;
  int         dones = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_tdata = 8'h00;
  logic       prev_rempty = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, then account for the coming edge.
  task automatic tick(input bit rdy, input bit hold_empty, input bit st, input bit rs);
    @(negedge clk);
    tready = rdy;
    start  = st;
    rst    = rs;
    rempty = hold_empty || (fifo.size() == 0);
    rdata  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1;
    if (rs) check("no_pop_in_reset", rinc, 1'b0);
    if (rinc === 1'b1) check("rinc_legal", {rempty, tready, tvalid}, 3'b011);
    if (!rs && prev_stall && rempty == prev_rempty)
      check("tdata_hold", {tvalid, tdata}, {1'b1, prev_tdata});
    if (done === 1'b1) check("done_cs_busy_low", {cs, busy}, 2'b00);
    prev_stall  = (tvalid === 1'b1) && !rdy && !rs;
    prev_tdata  = tdata;
    prev_rempty = rempty;
    if (!rs && tvalid === 1'b1 && rdy) obs.push_back(tdata);
    if (rinc === 1'b1 && fifo.size() != 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    if (done === 1'b1) dones++;
  endtask

  task automatic preload_random();
    while (fifo.size() < FRAME_DATA) fifo.push_back(8'($urandom_range(0, 255)));
  endtask

  // rdy_mode: 0 always ready, 1 toggling, 2 random. empty_at: pop count that opens a forced-empty window.
  task automatic run_frame(input string name, input int rdy_mode, input int empty_at,
                           input int empty_len, input bit spam);
    logic [7:0] exp[$];
    logic [7:0] cmdv;
    int  cyc;
    int  win;
    bit  win_used;
    bit  rdy;
    bit  hold;
    bit  st;
    int  n;

    cmdv = 8'h80;
`ifdef LCD_VCOM_EN
    if (vcom_model) cmdv = cmdv | 8'h40;
`endif
    exp = {};
    exp.push_back(cmdv);
    for (int l = 1; l <= NL; l++) begin
      exp.push_back(8'(l));
      for (int b = 0; b < LB; b++) exp.push_back(fifo[(l - 1) * LB + b]);
      exp.push_back(8'h00);
    end
    exp.push_back(8'h00);

    obs = {};
    pops = 0;
    dones = 0;
    prev_stall = 1'b0;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check({name, "_idle_no_valid"}, tvalid, 1'b0);

    cyc = 0;
    win = 0;
    win_used = 1'b0;
    while (dones == 0 && cyc < 3000) begin
      case (rdy_mode)
        0: rdy = 1'b1;
        1: rdy = cyc[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (empty_at >= 0 && !win_used && pops == empty_at) begin
        win = empty_len;
        win_used = 1'b1;
      end
      hold = (win > 0);
      st = spam && (obs.size() < exp.size()) && ($urandom_range(0, 1) == 1);
      tick(rdy, hold, st, 1'b0);
      if (cyc == 0) check({name, "_cs_busy_up"}, {cs, busy}, 2'b11);
      if (hold) begin
        check({name, "_stall_tvalid"}, tvalid, 1'b0);
        check({name, "_stall_rinc"}, rinc, 1'b0);
        win--;
      end
      cyc++;
    end
    check({name, "_done_seen"}, dones, 1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check({name, "_done_one_cycle"}, {done, cs, busy}, 3'b000);
    check({name, "_stream_len"}, obs.size(), exp.size());
    n = (obs.size() < exp.size()) ? obs.size() : exp.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", name, i), obs[i], exp[i]);
    check({name, "_pops"}, pops, FRAME_DATA);
    if (dones > 0) vcom_model = ~vcom_model;
    $display("frame %s: cmd=%02h bytes=%0d pops=%0d cycles=%0d", name, cmdv, obs.size(), pops, cyc);
  endtask

  initial begin
    int k;

    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_outputs", {cs, busy, done, tvalid, rinc}, 5'b00000);
    check("reset_tdata", tdata, 8'h00);
    $display("reset: cs=%0b busy=%0b tvalid=%0b", cs, busy, tvalid);

    fifo = {8'hA1, 8'hA2, 8'hB1, 8'hB2};
    run_frame("basic", 0, -1, 0, 1'b0);

    preload_random();
    run_frame("empty_stall", 0, 1, 10, 1'b0);

    fifo = {8'hA1, 8'hA2, 8'hB1, 8'hB2};
    run_frame("tready_toggle", 1, -1, 0, 1'b0);

    preload_random();
    run_frame("start_spam", 2, -1, 0, 1'b1);

    // Reset while streaming the first line's data.
    preload_random();
    pops = 0;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    k = 0;
    while (pops < 1 && k < 50) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      k++;
    end
    check("midreset_reached_data", pops, 1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("midreset_outputs", {cs, busy, done, tvalid, rinc}, 5'b00000);
    check("midreset_tdata", tdata, 8'h00);
    check("midreset_fifo_kept", fifo.size(), FRAME_DATA - 1);
    $display("midreset: fifo_left=%0d cs=%0b", fifo.size(), cs);
    vcom_model = 1'b0;
    preload_random();
    run_frame("after_reset", 0, -1, 0, 1'b0);

    for (int f = 0; f < 4; f++) begin
      preload_random();
      run_frame($sformatf("random%0d", f), 2, ($urandom_range(0, 1) == 1) ? 3 : 1,
                $urandom_range(1, 12), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_line_sequencer.md
LCD_LINE_SEQUENCER -- requirements
Module: lcd_line_sequencer

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 50, meaning data bytes per display line (400 px / 8).
REQ-002 SHALL have parameter NUM_LINES, default 240, meaning lines per frame; line address is 8 bits, 1-based.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_start  input  1  one-cycle frame-start request.
REQ-006 SHALL have port i_rempty  input  1  FIFO empty flag, read-clock domain.
REQ-007 SHALL have port i_rdata  input  8  FIFO head byte, valid while i_rempty=0.
REQ-008 SHALL have port o_rinc  output  1  FIFO pop strobe.
REQ-009 SHALL have port o_tdata  output  8  byte to the SPI serializer.
REQ-010 SHALL have port o_tvalid  output  1  o_tdata valid.
REQ-011 SHALL have port i_tready  input  1  serializer accepts the byte.
REQ-012 SHALL have port o_cs  output  1  panel chip select, high for the whole frame.
REQ-013 SHALL have port o_busy  output  1  frame in progress.
REQ-014 SHALL have port o_done  output  1  one-cycle pulse when the frame completes.

Function
REQ-015 SHALL implement FSM states IDLE, CMD, ADDR, DATA, DUMMY, TRAIL.
REQ-016 SHALL leave IDLE for CMD on i_start=1 and set o_cs=1 and o_busy=1 from the next cycle; SHALL ignore i_start in every other state.
REQ-017 SHALL transfer a byte only when o_tvalid and i_tready are both 1; o_tdata SHALL hold stable while o_tvalid=1 and i_tready=0.
REQ-018 SHALL emit 0x80 (write command, M1 per REQ-029) in CMD, then go to ADDR with line counter = 1.
REQ-019 SHALL emit the line counter in ADDR, then go to DATA with byte counter = 0.
REQ-020 SHALL, in DATA, drive o_tvalid = !i_rempty, o_tdata = i_rdata and o_rinc = !i_rempty & i_tready (pass-through, zero latency); byte counter increments per transfer.
REQ-021 SHALL, on FIFO empty in mid-line, stall with o_tvalid=0 and o_rinc=0 indefinitely, with no timeout and no data loss.
REQ-022 SHALL, after the LINE_BYTES-th data transfer, go to DUMMY and emit 0x00.
REQ-023 SHALL, after DUMMY: if line counter < NUM_LINES, increment it and go to ADDR; else go to TRAIL.
REQ-024 SHALL emit 0x00 in TRAIL, then go to IDLE, pulse o_done for one cycle, and drop o_cs and o_busy in that same cycle.
REQ-025 SHALL never assert o_rinc outside DATA, nor when i_rempty=1.
REQ-026 SHALL size counters to $clog2 of their maximum values and SHALL never wrap within a frame.

Reset
REQ-027 SHALL, on i_rst=1 at a clock edge (including mid-frame), enter IDLE and clear the counters; o_cs, o_busy, o_done, o_tvalid and o_rinc SHALL be 0 and o_tdata 0x00.
REQ-028 SHALL NOT pop the FIFO during reset; FIFO contents remaining after a reset SHALL be left for the next frame.

Configuration
REQ-029 SHALL support macro LCD_VCOM_EN: when defined, a VCOM bit toggles at every o_done and is driven on command bit 6 (0x80/0xC0 alternate per frame), reset value 0; when undefined, the command is always 0x80.

Structure
REQ-030 SHALL place the state enum, the command constants (0x80, VCOM mask 0x40) and the dummy byte 0x00 in shared package lcd_pkg.
REQ-031 SHALL be a single module with no sub-modules; the FIFO and the serializer remain external.

Verification
REQ-032 Bench: LINE_BYTES=2, NUM_LINES=2, FIFO preloaded with A1 A2 B1 B2, tready=1, start -> stream 80 01 A1 A2 00 02 B1 B2 00 00; o_done 1 cycle; 4 pops total.
REQ-033 Bench: FIFO empty after the 1st data byte for 10 cycles -> o_tvalid=0 and o_rinc=0 for the 10 cycles; stream resumes with no lost or duplicated byte.
REQ-034 Bench: i_tready toggled 1/0 every cycle -> o_tdata is stable while stalled; byte sequence identical to REQ-032.
REQ-035 Bench: i_rst pulsed mid-DATA -> next cycle IDLE, o_cs=0, no pop; a new start re-emits 80 01.
REQ-036 Bench: LCD_VCOM_EN defined, two frames -> command bytes 80 then C0; undefined -> 80 both frames.
REQ-037 Bench: i_start pulsed while busy -> ignored; exactly one o_done per frame.
